// File: rtl/l2_mem_resp_pkg.sv
// Shared types and constants for the L2 memory responder.
// Message codes, flit field offsets, FSM states and line geometry.
package l2_mem_resp_pkg;

  localparam logic [7:0] MSG_LOAD_MEM      = 8'd19;
  localparam logic [7:0] MSG_STORE_MEM     = 8'd20;
  localparam logic [7:0] MSG_LOAD_MEM_ACK  = 8'd24;
  localparam logic [7:0] MSG_STORE_MEM_ACK = 8'd25;

  localparam int HDR_SRC_LSB  = 34;
  localparam int HDR_LEN_LSB  = 22;
  localparam int HDR_TYPE_LSB = 14;
  localparam int HDR_MSHR_LSB = 6;
  localparam int ADDR_LINE_LSB = 6;

  localparam int LINE_WORDS = 8;
  localparam int LINE_BITS  = LINE_WORDS * 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_SRC,
    S_RX_DATA,
    S_DELAY,
    S_TX_HDR,
    S_TX_DATA,
    S_DRAIN
  } state_t;

  function automatic logic [63:0] mk_hdr(
    input logic [29:0] src,
    input logic [7:0]  typ,
    input logic [7:0]  len,
    input logic [7:0]  mshr
  );
    logic [63:0] h;
    h = '0;
    h[HDR_SRC_LSB  +: 30] = src;
    h[HDR_LEN_LSB  +: 8]  = len;
    h[HDR_TYPE_LSB +: 8]  = typ;
    h[HDR_MSHR_LSB +: 8]  = mshr;
    return h;
  endfunction

endpackage

// File: rtl/l2_mem_resp_array.sv
// Line store: full-line write in one cycle, combinational line read.
// Contents are deliberately not reset.
module l2_mem_resp_array
  import l2_mem_resp_pkg::*;
#(
  parameter int MEM_LINES = 16,
  localparam int IW = $clog2(MEM_LINES)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [IW-1:0]        i_widx,
  input  logic [LINE_BITS-1:0] i_wline,
  input  logic [IW-1:0]        i_ridx,
  output logic [LINE_BITS-1:0] o_rline
);

  logic [LINE_BITS-1:0] r_mem [MEM_LINES];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wline;
  end

  assign o_rline = r_mem[i_ridx];

endmodule

// File: rtl/l2_mem_responder.sv
// Memory-side NoC responder for L2 LOAD_MEM / STORE_MEM requests.
// Define MEM_RESP_DELAY_EN to insert RESP_DELAY cycles before each ack.
module l2_mem_responder
  import l2_mem_resp_pkg::*;
#(
  parameter int MEM_LINES  = 16,
  parameter int RESP_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        noc2_valid_in,
  input  logic [63:0] noc2_data_in,
  output logic        noc2_ready_out,
  output logic        noc3_valid_out,
  output logic [63:0] noc3_data_out,
  input  logic        noc3_ready_in,
  output logic        busy,
  output logic        err_unsupported
);

  localparam int IW = $clog2(MEM_LINES);

  state_t               r_state;
  logic                 r_is_load;
  logic [7:0]           r_mshr;
  logic [29:0]          r_src;
  logic [IW-1:0]        r_idx;
  logic [2:0]           r_widx;
  logic [7:0]           r_cnt;
  logic [LINE_BITS-1:0] r_buf;
  logic                 r_valid;
  logic [63:0]          r_data;
  logic                 r_err;
`ifdef MEM_RESP_DELAY_EN
  logic [15:0]          r_dcnt;
`endif

  logic                 w_rx;
  logic                 w_tx;
  logic [7:0]           w_type;
  logic [7:0]           w_len;
  logic                 w_we;
  logic                 w_last;
  logic [29:0]          w_src;
  logic [63:0]          w_hdr;
  logic [LINE_BITS-1:0] w_wline;
  logic [LINE_BITS-1:0] w_rline;

  assign noc2_ready_out = r_state inside
    {S_IDLE, S_RX_ADDR, S_RX_SRC, S_RX_DATA, S_DRAIN};
  assign busy            = r_state != S_IDLE;
  assign noc3_valid_out  = r_valid;
  assign noc3_data_out   = r_data;
  assign err_unsupported = r_err;

  assign w_rx   = noc2_valid_in & noc2_ready_out;
  assign w_tx   = r_valid & noc3_ready_in;
  assign w_type = noc2_data_in[HDR_TYPE_LSB +: 8];
  assign w_len  = noc2_data_in[HDR_LEN_LSB +: 8];

  // Line commits on word 7 together with the buffered words 0..6
  assign w_we = w_rx & ~rst & (r_state == S_RX_DATA)
              & (r_widx == 3'd7);
  assign w_wline = {noc2_data_in, r_buf[LINE_BITS-65:0]};

  assign w_last = w_we
    | (w_rx & (r_state == S_RX_SRC) & r_is_load);

  assign w_src = (r_state == S_RX_SRC)
    ? noc2_data_in[HDR_SRC_LSB +: 30] : r_src;

  assign w_hdr = mk_hdr(
    w_src,
    r_is_load ? MSG_LOAD_MEM_ACK : MSG_STORE_MEM_ACK,
    r_is_load ? 8'd8 : 8'd0,
    r_mshr);

  l2_mem_resp_array #(
    .MEM_LINES(MEM_LINES)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_widx (r_idx),
    .i_wline(w_wline),
    .i_ridx (r_idx),
    .o_rline(w_rline)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_widx  <= '0;
      r_cnt   <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_rx) begin
          r_mshr    <= noc2_data_in[HDR_MSHR_LSB +: 8];
          r_is_load <= w_type == MSG_LOAD_MEM;
          if (w_type == MSG_LOAD_MEM ||
              w_type == MSG_STORE_MEM) begin
            r_state <= S_RX_ADDR;
          end else begin
            r_err <= 1'b1;
            if (w_len != 8'd0) begin
              r_state <= S_DRAIN;
              r_cnt   <= w_len;
            end
          end
        end
        S_RX_ADDR: if (w_rx) begin
          r_idx   <= noc2_data_in[ADDR_LINE_LSB +: IW];
          r_state <= S_RX_SRC;
        end
        S_RX_SRC: if (w_rx) begin
          r_src   <= noc2_data_in[HDR_SRC_LSB +: 30];
          r_widx  <= '0;
          r_state <= S_RX_DATA;
        end
        S_RX_DATA: if (w_rx) begin
          r_buf[r_widx*64 +: 64] <= noc2_data_in;
          r_widx <= r_widx + 3'd1;
        end
`ifdef MEM_RESP_DELAY_EN
        S_DELAY: begin
          if (r_dcnt == 16'(RESP_DELAY - 1)) begin
            r_state <= S_TX_HDR;
            r_valid <= 1'b1;
            r_data  <= w_hdr;
          end else begin
            r_dcnt <= r_dcnt + 16'd1;
          end
        end
`endif
        S_TX_HDR: if (w_tx) begin
          if (r_is_load) begin
            r_state <= S_TX_DATA;
            r_buf   <= w_rline;
            r_data  <= w_rline[63:0];
            r_widx  <= '0;
          end else begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
          end
        end
        S_TX_DATA: if (w_tx) begin
          if (r_widx == 3'd7) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
          end else begin
            r_widx <= r_widx + 3'd1;
            r_buf  <= r_buf >> 64;
            r_data <= r_buf[127:64];
          end
        end
        S_DRAIN: if (w_rx) begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_last) begin
`ifdef MEM_RESP_DELAY_EN
        if (RESP_DELAY > 0) begin
          r_state <= S_DELAY;
          r_dcnt  <= '0;
        end else begin
          r_state <= S_TX_HDR;
          r_valid <= 1'b1;
          r_data  <= w_hdr;
        end
`else
        r_state <= S_TX_HDR;
        r_valid <= 1'b1;
        r_data  <= w_hdr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Randomized bench for l2_mem_responder against a line-array model.
// Honors MEM_RESP_DELAY_EN for the expected header latency.
module tb_l2_mem_responder;

  localparam int ML = 16;
  localparam int RD = 4;
`ifdef MEM_RESP_DELAY_EN
  localparam int EXP_WAIT = RD;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        clk;
  logic        rst;
  logic        noc2_valid_in;
  logic [63:0] noc2_data_in;
  logic        noc2_ready_out;
  logic        noc3_valid_out;
  logic [63:0] noc3_data_out;
  logic        noc3_ready_in;
  logic        busy;
  logic        err_unsupported;

  l2_mem_responder #(
    .MEM_LINES (ML),
    .RESP_DELAY(RD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .noc2_valid_in  (noc2_valid_in),
    .noc2_data_in   (noc2_data_in),
    .noc2_ready_out (noc2_ready_out),
    .noc3_valid_out (noc3_valid_out),
    .noc3_data_out  (noc3_data_out),
    .noc3_ready_in  (noc3_ready_in),
    .busy           (busy),
    .err_unsupported(err_unsupported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem_m [ML][8];
  logic [63:0] exp_w [8];
  logic [63:0] st_w  [8];
  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int tx_cnt = 0;

  always @(posedge clk) begin
    if (err_unsupported) err_cnt++;
    if (noc3_valid_out && noc3_ready_in) tx_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [63:0] a);
    return int'((a >> 6) % ML);
  endfunction

  function automatic logic [63:0] rq_hdr(input logic [7:0] typ,
                                         input logic [7:0] len,
                                         input logic [7:0] mshr);
    logic [63:0] h;
    h = {$urandom(), $urandom()};
    h[29:22] = len;
    h[21:14] = typ;
    h[13:6]  = mshr;
    return h;
  endfunction

  task automatic send(input logic [63:0] d);
    int n;
    n = 0;
    noc2_valid_in = 1'b1;
    noc2_data_in  = d;
    while (!noc2_ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 64'(n), 64'd0);
    @(negedge clk);
    noc2_valid_in = 1'b0;
    noc2_data_in  = '0;
  endtask

  task automatic get_resp(input bit is_load,
                          input logic [7:0] mshr,
                          input logic [29:0] src,
                          input int stall);
    int lat;
    int nfl;
    logic [63:0] want;
    logic [63:0] held;
    lat = 0;
    noc3_ready_in = 1'b0;
    while (!noc3_valid_out && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("hdr_latency", 64'(lat), 64'(EXP_WAIT));
    nfl = is_load ? 9 : 1;
    for (int i = 0; i < nfl; i++) begin
      if (i == 0)
        want = {src, 4'h0,
                is_load ? 8'd8 : 8'd0,
                is_load ? 8'd24 : 8'd25,
                mshr, 6'h0};
      else
        want = exp_w[i-1];
      held = noc3_data_out;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("hold_valid", 64'(noc3_valid_out), 64'd1);
        chk("hold_data", noc3_data_out, held);
        chk("req_blocked", 64'(noc2_ready_out), 64'd0);
      end
      chk($sformatf("flit%0d_valid", i),
          64'(noc3_valid_out), 64'd1);
      chk($sformatf("flit%0d_data", i), noc3_data_out, want);
      noc3_ready_in = 1'b1;
      @(negedge clk);
      noc3_ready_in = 1'b0;
    end
    chk("resp_end_valid", 64'(noc3_valid_out), 64'd0);
    chk("resp_end_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_store(input logic [63:0] addr,
                          input logic [7:0] mshr,
                          input logic [29:0] src,
                          input int stall);
    send(rq_hdr(8'd20, 8'd10, mshr));
    send(addr);
    send({src, $urandom_range(0, 15) == 0 ? 34'h0 :
          {2'b10, $urandom()}});
    for (int i = 0; i < 8; i++) send(st_w[i]);
    for (int i = 0; i < 8; i++) mem_m[line_of(addr)][i] = st_w[i];
    get_resp(1'b0, mshr, src, stall);
  endtask

  task automatic do_load(input logic [63:0] addr,
                         input logic [7:0] mshr,
                         input logic [29:0] src,
                         input int stall);
    send(rq_hdr(8'd19, 8'd2, mshr));
    send(addr);
    send({src, 2'b01, $urandom()});
    for (int i = 0; i < 8; i++) exp_w[i] = mem_m[line_of(addr)][i];
    get_resp(1'b1, mshr, src, stall);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_v"},   64'(noc3_valid_out), 64'd0);
    chk({tag, "_d"},   noc3_data_out, 64'd0);
    chk({tag, "_bsy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err_unsupported), 64'd0);
    chk({tag, "_rdy"}, 64'(noc2_ready_out), 64'd1);
  endtask

  task automatic do_unsup(input logic [7:0] typ,
                          input logic [7:0] len);
    int e0;
    int t0;
    e0 = err_cnt;
    t0 = tx_cnt;
    send(rq_hdr(typ, len, 8'($urandom())));
    chk("unsup_err_hi", 64'(err_unsupported), 64'd1);
    for (int i = 0; i < int'(len); i++) begin
      send({$urandom(), $urandom()});
      chk("drain_err_lo", 64'(err_unsupported), 64'd0);
      chk("drain_no_tx", 64'(noc3_valid_out), 64'd0);
    end
    @(negedge clk);
    chk("unsup_pulses", 64'(err_cnt - e0), 64'd1);
    chk("unsup_no_tx", 64'(tx_cnt - t0), 64'd0);
    chk("unsup_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int op;
    rst = 1'b1;
    noc2_valid_in = 1'b0;
    noc2_data_in  = '0;
    noc3_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");

    // Give every line known contents, via aliased addresses
    for (int l = 0; l < ML; l++) begin
      a = {$urandom(), $urandom()};
      a = (a & ~(64'(ML - 1) << 6)) | (64'(l) << 6);
      for (int i = 0; i < 8; i++) st_w[i] = {$urandom(), $urandom()};
      do_store(a, 8'(l), 30'($urandom()), 0);
    end

    for (int i = 0; i < 8; i++) st_w[i] = 64'(i + 1);
    do_store(64'h40, 8'h05, 30'h12345678, 0);
    do_load(64'h40, 8'h06, 30'h12345678, 0);
    do_load(64'h40, 8'h07, 30'h2abcdef1, 5);

    do_unsup(8'd31, 8'd3);
    do_unsup(8'd99, 8'd0);

    // Reset partway through a store's data words
    send(rq_hdr(8'd20, 8'd10, 8'h11));
    send(64'h80);
    send({30'h155, 34'h0});
    for (int i = 0; i < 4; i++) send(64'hdead_0000 + 64'(i));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_ack", 64'(noc3_valid_out), 64'd0);
    do_load(64'h80, 8'h12, 30'h3ff0001, 0);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      a = {$urandom(), $urandom()};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (op < 4) begin
        for (int i = 0; i < 8; i++) st_w[i] = {$urandom(), $urandom()};
        do_store(a, 8'($urandom()), 30'($urandom()),
                 $urandom_range(0, 3));
        if (op == 0)
          do_load(a ^ (64'h1 << 20), 8'($urandom()),
                  30'($urandom()), $urandom_range(0, 3));
      end else if (op < 8) begin
        do_load(a, 8'($urandom()), 30'($urandom()),
                $urandom_range(0, 3));
      end else begin
        do_unsup(8'($urandom_range(26, 200)),
                 8'($urandom_range(0, 4)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
